// File: rtl/sdr_cfg_ctrl.sv
// Runtime configuration controller: parses framed UART commands and updates the carrier
// NCO phase increment and CIC decimation ratio, answering each frame with ACK/NAK.
module sdr_cfg_ctrl #(
   parameter logic [63:0] PINC_RESET  = 64'h01E1E1E1E1DBDFC0,
   parameter logic [15:0] DEC_RESET   = 16'd1024,
   parameter int unsigned TIMEOUT_CYC = 2000000
) (
   input  logic        osc_clk,
   input  logic        rst_n,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Tx_DV,
   output logic [7:0]  o_Tx_Byte,
   input  logic        i_Tx_Done,
   output logic [63:0] phase_inc_carr,
   output logic [15:0] decimation_ratio,
   output logic        cfg_update,
   output logic        busy
);

   localparam logic [7:0] SyncByte = 8'hA5;
   localparam logic [7:0] AckByte  = 8'h06;
   localparam logic [7:0] NakByte  = 8'h15;
   localparam logic [7:0] CmdPinc  = 8'h01;
   localparam logic [7:0] CmdDec   = 8'h02;
   localparam logic [7:0] CmdPing  = 8'h03;

   localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      StIdle, StCmd, StPayload, StCheck, StVerify, StCommit, StResp, StWait
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [63:0]     shadow_q, shadow_d;
   logic [7:0]      xor_q, xor_d;
   logic            chk_ok_q, chk_ok_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [63:0]     pinc_q, pinc_d;
   logic [15:0]     dec_q, dec_d;
   logic            tx_dv_q, tx_dv_d;
   logic [7:0]      tx_byte_q, tx_byte_d;
   logic            upd_q, upd_d;

   logic in_frame;
   logic timeout;

   assign in_frame = (state_q == StCmd) || (state_q == StPayload) || (state_q == StCheck);
   assign timeout  = in_frame && !i_Rx_DV && (tmo_q >= TmoLast);

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      xor_d     = xor_q;
      chk_ok_d  = chk_ok_q;
      tmo_d     = '0;
      pinc_d    = pinc_q;
      dec_d     = dec_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      upd_d     = 1'b0;

      // Idle-gap counter only runs between bytes of a frame and never wraps
      if (in_frame && !i_Rx_DV) begin
         tmo_d = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (i_Rx_DV && (i_Rx_Byte == SyncByte)) begin
               state_d  = StCmd;
               shadow_d = '0;
               xor_d    = '0;
            end
         end
         StCmd: begin
            if (i_Rx_DV) begin
               cmd_d = i_Rx_Byte;
               xor_d = i_Rx_Byte;
               case (i_Rx_Byte)
                  CmdPinc: begin
                     cnt_d   = 4'd8;
                     state_d = StPayload;
                  end
                  CmdDec: begin
                     cnt_d   = 4'd2;
                     state_d = StPayload;
                  end
                  CmdPing: begin
                     cnt_d   = 4'd0;
                     state_d = StCheck;
                  end
                  default: begin
                     state_d   = StResp;
                     tx_dv_d   = 1'b1;
                     tx_byte_d = NakByte;
                  end
               endcase
            end
         end
         StPayload: begin
            if (i_Rx_DV) begin
               shadow_d = {shadow_q[55:0], i_Rx_Byte};
               xor_d    = xor_q ^ i_Rx_Byte;
               cnt_d    = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            if (i_Rx_DV) begin
               chk_ok_d = (i_Rx_Byte == xor_q);
               state_d  = StVerify;
            end
         end
         StVerify: begin
            if (chk_ok_q) begin
               state_d = StCommit;
            end else begin
               state_d   = StResp;
               tx_dv_d   = 1'b1;
               tx_byte_d = NakByte;
            end
         end
         StCommit: begin
            state_d = StResp;
            tx_dv_d = 1'b1;
            if ((cmd_q == CmdDec) && (shadow_q[15:0] < 16'd2)) begin
               tx_byte_d = NakByte;
            end else begin
               tx_byte_d = AckByte;
               if (cmd_q == CmdPinc) begin
                  pinc_d = shadow_q;
                  upd_d  = 1'b1;
               end
               if (cmd_q == CmdDec) begin
                  dec_d = shadow_q[15:0];
                  upd_d = 1'b1;
               end
            end
         end
         StResp: begin
            state_d = StWait;
         end
         StWait: begin
            if (i_Tx_Done) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A stalled frame is dropped silently together with its partial payload
      if (timeout) begin
         state_d  = StIdle;
         shadow_d = '0;
         xor_d    = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge osc_clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cmd_q     <= '0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         xor_q     <= '0;
         chk_ok_q  <= 1'b0;
         tmo_q     <= '0;
         pinc_q    <= PINC_RESET;
         dec_q     <= DEC_RESET;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= '0;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         xor_q     <= xor_d;
         chk_ok_q  <= chk_ok_d;
         tmo_q     <= tmo_d;
         pinc_q    <= pinc_d;
         dec_q     <= dec_d;
         tx_dv_q   <= tx_dv_d;
         tx_byte_q <= tx_byte_d;
         upd_q     <= upd_d;
      end
   end

   assign o_Tx_DV          = tx_dv_q;
   assign o_Tx_Byte        = tx_byte_q;
   assign phase_inc_carr   = pinc_q;
   assign decimation_ratio = dec_q;
   assign cfg_update       = upd_q;
   assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_sdr_cfg_ctrl.sv
// Bench for sdr_cfg_ctrl: frame-level reference model predicts response timing and
// committed values; a negedge process compares every output each cycle.
`timescale 1ns/1ps
module tb_sdr_cfg_ctrl;

   localparam logic [63:0] PincRst = 64'h01E1E1E1E1DBDFC0;
   localparam logic [15:0] DecRst  = 16'd1024;
   localparam int          Tmo     = 40;

   logic        clk;
   logic        rst_n;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic [63:0] pinc;
   logic [15:0] dec;
   logic        upd;
   logic        busy;

   sdr_cfg_ctrl #(
      .PINC_RESET  (PincRst),
      .DEC_RESET   (DecRst),
      .TIMEOUT_CYC (Tmo)
   ) dut (
      .osc_clk          (clk),
      .rst_n            (rst_n),
      .i_Rx_DV          (rx_dv),
      .i_Rx_Byte        (rx_byte),
      .o_Tx_DV          (tx_dv),
      .o_Tx_Byte        (tx_byte),
      .i_Tx_Done        (tx_done),
      .phase_inc_carr   (pinc),
      .decimation_ratio (dec),
      .cfg_update       (upd),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit          chk_en     = 1'b0;
   logic [63:0] m_pinc;
   logic [15:0] m_dec;
   logic [7:0]  m_tx_byte;
   int          pend_edge  = -1;
   bit          pend_is_pinc;
   logic [63:0] pend_val;
   int          upd_edge   = -1;
   int          resp_edge  = -1;
   logic [7:0]  resp_code;
   int          busy_start = -1;
   int          busy_end   = -1;
   int          last_edge  = 0;
   logic [7:0]  frm[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (pend_edge >= 0 && cyc >= pend_edge) begin
            if (pend_is_pinc) m_pinc = pend_val;
            else              m_dec  = pend_val[15:0];
            pend_edge = -1;
         end
         if (resp_edge >= 0 && cyc >= resp_edge) m_tx_byte = resp_code;
         check("phase_inc_carr", pinc, m_pinc);
         check("decimation_ratio", 64'(dec), 64'(m_dec));
         check("cfg_update", 64'(upd), 64'(cyc == upd_edge));
         check("o_Tx_DV", 64'(tx_dv), 64'(cyc == resp_edge));
         check("o_Tx_Byte", 64'(tx_byte), 64'(m_tx_byte));
         check("busy", 64'(busy),
               64'(busy_start >= 0 && cyc >= busy_start && (busy_end < 0 || cyc < busy_end)));
      end
   end

   task automatic do_reset(input int n);
      chk_en = 1'b0;
      @(posedge clk); #1;
      rst_n   = 1'b0;
      rx_dv   = 1'b0;
      tx_done = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      m_pinc     = PincRst;
      m_dec      = DecRst;
      m_tx_byte  = 8'h00;
      pend_edge  = -1;
      upd_edge   = -1;
      resp_edge  = -1;
      busy_start = -1;
      busy_end   = -1;
      chk_en     = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_dv     = 1'b1;
      rx_byte   = b;
      last_edge = cyc + 1;
      @(posedge clk); #1;
      rx_dv = 1'b0;
   endtask

   task automatic wait_resp();
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = tx_dv;
      end
      check("response_seen", 64'(seen), 64'd1);
   endtask

   // Sends frm, predicts the outcome from the frame contents, then completes the Tx handshake
   task automatic run_frame(input bit expect_tmo, input bit byte_in_wait);
      int          e[$];
      int          s = 0;
      int          n;
      int          ec;
      bit          seen = 1'b0;
      logic [7:0]  cmd;
      logic [7:0]  x;
      logic [63:0] val;
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i]);
         e.push_back(last_edge);
         if (!seen && frm[i] == 8'hA5) begin
            seen       = 1'b1;
            s          = i;
            busy_start = last_edge;
            busy_end   = -1;
         end
      end
      if (expect_tmo) begin
         busy_end = e[e.size()-1] + Tmo;
         repeat (Tmo + 6) @(posedge clk);
         #1;
         return;
      end
      cmd = frm[s+1];
      if (cmd == 8'h00 || cmd > 8'h03) begin
         resp_code = 8'h15;
         resp_edge = e[s+1];
      end else begin
         n   = (cmd == 8'h01) ? 8 : (cmd == 8'h02) ? 2 : 0;
         val = '0;
         x   = cmd;
         for (int k = 0; k < n; k++) begin
            val = {val[55:0], frm[s+2+k]};
            x   = x ^ frm[s+2+k];
         end
         ec = e[s+2+n];
         if (frm[s+2+n] != x) begin
            resp_code = 8'h15;
            resp_edge = ec + 1;
         end else if (cmd == 8'h02 && val[15:0] < 16'd2) begin
            resp_code = 8'h15;
            resp_edge = ec + 2;
         end else begin
            resp_code = 8'h06;
            resp_edge = ec + 2;
            if (cmd != 8'h03) begin
               upd_edge     = ec + 2;
               pend_edge    = ec + 2;
               pend_is_pinc = (cmd == 8'h01);
               pend_val     = val;
            end
         end
      end
      wait_resp();
      if (byte_in_wait) send_byte(8'hA5);
      @(posedge clk); #1;
      tx_done  = 1'b1;
      busy_end = cyc + 1;
      @(posedge clk); #1;
      tx_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
      tx_done = 1'b0;
      do_reset(3);
      @(negedge clk);
      check("rst_pinc", pinc, PincRst);
      check("rst_dec", 64'(dec), 64'd1024);
      check("rst_tx_dv", 64'(tx_dv), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);

      // Tx done while idle has no effect
      @(posedge clk); #1 tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;

      frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      run_frame(1'b0, 1'b0);
      check("pinc_commit", pinc, 64'h0000_0000_1234_5678);
      check("pinc_ack", 64'(tx_byte), 64'h06);

      frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h77, 8'h4C};
      run_frame(1'b0, 1'b0);
      check("pinc_badchk_hold", pinc, 64'h0000_0000_1234_5678);
      check("pinc_badchk_nak", 64'(tx_byte), 64'h15);

      frm = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h03};
      run_frame(1'b0, 1'b0);
      check("dec_256", 64'(dec), 64'd256);
      check("dec_ack", 64'(tx_byte), 64'h06);

      frm = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h03};
      run_frame(1'b0, 1'b0);
      check("dec_lt2_hold", 64'(dec), 64'd256);
      check("dec_lt2_nak", 64'(tx_byte), 64'h15);

      frm = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'hFF};
      run_frame(1'b0, 1'b1);
      check("badchk_hold", 64'(dec), 64'd256);

      frm = '{8'hA5, 8'h07};
      run_frame(1'b0, 1'b0);
      check("unknown_cmd_nak", 64'(tx_byte), 64'h15);

      // Sync value inside the payload is plain data
      frm = '{8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFD};
      run_frame(1'b0, 1'b0);
      check("dec_a55a", 64'(dec), 64'hA55A);

      frm = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33};
      run_frame(1'b1, 1'b0);
      check("tmo_idle", 64'(busy), 64'd0);

      frm = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h12};
      run_frame(1'b0, 1'b0);
      check("after_tmo_dec", 64'(dec), 64'd16);

      frm = '{8'h11, 8'h22, 8'hA5, 8'h03, 8'h03};
      run_frame(1'b0, 1'b0);
      check("ping_ack", 64'(tx_byte), 64'h06);
      check("ping_no_change", 64'(dec), 64'd16);

      // Reset in the middle of a payload
      frm = '{8'hA5, 8'h01, 8'hAA, 8'hBB};
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i]);
         if (i == 0) begin
            busy_start = last_edge;
            busy_end   = -1;
         end
      end
      do_reset(3);
      @(negedge clk);
      check("midrst_pinc", pinc, PincRst);
      check("midrst_dec", 64'(dec), 64'd1024);
      check("midrst_tx_dv", 64'(tx_dv), 64'd0);
      check("midrst_tx_byte", 64'(tx_byte), 64'd0);
      check("midrst_upd", 64'(upd), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);

      frm = '{8'hA5, 8'h03, 8'h03};
      run_frame(1'b0, 1'b0);
      check("final_ping_ack", 64'(tx_byte), 64'h06);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
